idct_block_scheduler: RTL and testbench

IDCT_BLOCK_SCHEDULER -- requirements
Module: idct_block_scheduler

---
 rtl/idct_pkg.sv | 25 ++
 rtl/idct_out_monitor.sv | 56 +++++
 rtl/idct_block_scheduler.sv | 143 ++++++++++++++
 tb/tb_idct_block_scheduler.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/idct_pkg.sv
// Shared definitions for the IDCT block scheduler: FSM encoding and default block/timeout sizes.
package idct_pkg;

  localparam int unsigned BLK_SIZE_DEF = 64;
  localparam int unsigned TIMEOUT_DEF  = 255;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD     = 2'd1,
    WAIT_OUT = 2'd2,
    DRAIN    = 2'd3
  } state_e;

  // States in which upstream coefficients may be accepted.
  function automatic logic is_input_state(input state_e s);
    logic r;
    if ((s == IDLE) || (s == LOAD)) begin
      r = 1'b1;
    end else begin
      r = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/idct_out_monitor.sv
// Tracks core results for one block: cycles waited for the first result and results counted.
module idct_out_monitor
  import idct_pkg::*;
#(
  parameter int unsigned BLK_SIZE = BLK_SIZE_DEF,
  parameter int unsigned TIMEOUT  = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_b,
  input  logic wait_en,
  input  logic drain_en,
  input  logic out_start,
  output logic first_out_s,
  output logic timeout_s,
  output logic last_out_s
);

  localparam int unsigned WW = $clog2(TIMEOUT + 1);
  localparam int unsigned OW = $clog2(BLK_SIZE + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);
  localparam logic [OW-1:0] OUT_LAST  = OW'(BLK_SIZE - 1);

  logic [WW-1:0] wait_cnt_r;
  logic [OW-1:0] out_cnt_r;

  // Event decode; the first result arrives while waiting and is result number one.
  always_comb begin
    first_out_s = wait_en && out_start;
    timeout_s   = wait_en && !out_start && (wait_cnt_r == WAIT_LAST);
    last_out_s  = drain_en && out_start && (out_cnt_r == OUT_LAST);
  end

  // Wait-cycle and result counters, cleared whenever the block is not in their phase.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      wait_cnt_r <= '0;
      out_cnt_r  <= '0;
    end else begin
      if (wait_en && !out_start) begin
        wait_cnt_r <= wait_cnt_r + WW'(1'b1);
      end else begin
        wait_cnt_r <= '0;
      end
      if (first_out_s) begin
        out_cnt_r <= OW'(1'b1);
      end else if (drain_en && out_start) begin
        out_cnt_r <= last_out_s ? '0 : out_cnt_r + OW'(1'b1);
      end else if (!(wait_en || drain_en)) begin
        out_cnt_r <= '0;
      end else begin
        out_cnt_r <= out_cnt_r;
      end
    end
  end

endmodule

// File: rtl/idct_block_scheduler.sv
// Feeds one 8x8 block of coefficients to the IDCT core, then tracks its results,
// flagging mode inconsistencies and a core that never answers.
module idct_block_scheduler
  import idct_pkg::*;
#(
  parameter int unsigned BLK_SIZE = BLK_SIZE_DEF,
  parameter int unsigned TIMEOUT  = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic        in_mode,
  output logic        core_valid,
  output logic [15:0] core_data,
  output logic        core_mode,
  input  logic        core_out_start,
  input  logic        core_out_mode,
  output logic        blk_done,
  output logic        busy,
  output logic        mode_err,
  output logic        timeout_err,
  output logic [7:0]  blk_count
);

  localparam logic [5:0] LOAD_LAST = 6'(BLK_SIZE - 1);

  state_e      state_r, state_nxt_s;
  logic [5:0]  load_cnt_r;
  logic        mode_r;
  logic        xfer_s, first_out_s, timeout_s, last_out_s;
  logic        counted_s, err_set_s, in_ready_nxt_s, busy_nxt_s, fwd_mode_s;
  logic        in_ready_r, core_valid_r, core_mode_r, blk_done_r, busy_r;
  logic        mode_err_r, timeout_err_r;
  logic [15:0] core_data_r;
  logic [7:0]  blk_count_r;

  assign xfer_s = in_valid && in_ready_r;

  idct_out_monitor #(.BLK_SIZE(BLK_SIZE), .TIMEOUT(TIMEOUT)) u_out_monitor (
    .clk         (clk),
    .rst_b       (rst_b),
    .wait_en     (state_r == WAIT_OUT),
    .drain_en    (state_r == DRAIN),
    .out_start   (core_out_start),
    .first_out_s (first_out_s),
    .timeout_s   (timeout_s),
    .last_out_s  (last_out_s)
  );

  // State register and input transfer counter.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_r    <= IDLE;
      load_cnt_r <= 6'd0;
    end else begin
      state_r <= state_nxt_s;
      if (state_r == IDLE && xfer_s) begin
        load_cnt_r <= 6'd1;
      end else if (state_r == LOAD && xfer_s) begin
        load_cnt_r <= (load_cnt_r == LOAD_LAST) ? 6'd0 : load_cnt_r + 6'd1;
      end else if (state_r != LOAD) begin
        load_cnt_r <= 6'd0;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:     state_nxt_s = xfer_s ? LOAD : IDLE;
      LOAD:     state_nxt_s = (xfer_s && load_cnt_r == LOAD_LAST) ? WAIT_OUT : LOAD;
      WAIT_OUT: begin
        if (first_out_s) begin
          state_nxt_s = DRAIN;
        end else if (timeout_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT_OUT;
        end
      end
      DRAIN:    state_nxt_s = last_out_s ? IDLE : DRAIN;
      default:  state_nxt_s = IDLE;
    endcase
  end

  // Output decode; in_ready stays low for the blk_done cycle so no block straddles it.
  always_comb begin
    in_ready_nxt_s = is_input_state(state_nxt_s) && !last_out_s;
    busy_nxt_s     = (state_nxt_s != IDLE);
    counted_s      = first_out_s || (state_r == DRAIN && core_out_start);
    fwd_mode_s     = (state_r == IDLE) ? in_mode : mode_r;
    err_set_s      = (state_r == LOAD && xfer_s && in_mode != mode_r)
                   || (counted_s && core_out_mode != mode_r)
                   || (is_input_state(state_r) && core_out_start);
  end

  // Registered outputs, forwarding path and sticky status.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      in_ready_r    <= 1'b0;
      busy_r        <= 1'b0;
      core_valid_r  <= 1'b0;
      core_data_r   <= 16'd0;
      core_mode_r   <= 1'b0;
      mode_r        <= 1'b0;
      mode_err_r    <= 1'b0;
      timeout_err_r <= 1'b0;
      blk_done_r    <= 1'b0;
      blk_count_r   <= 8'd0;
    end else begin
      in_ready_r    <= in_ready_nxt_s;
      busy_r        <= busy_nxt_s;
      core_valid_r  <= xfer_s;
      if (xfer_s) begin
        core_data_r <= in_data;
        core_mode_r <= fwd_mode_s;
      end
      if (state_r == IDLE && xfer_s) begin
        mode_r <= in_mode;
      end
      mode_err_r    <= mode_err_r | err_set_s;
      timeout_err_r <= timeout_err_r | timeout_s;
      blk_done_r    <= last_out_s;
      if (last_out_s) begin
        blk_count_r <= blk_count_r + 8'd1;
      end
    end
  end

  assign in_ready    = in_ready_r;
  assign core_valid  = core_valid_r;
  assign core_data   = core_data_r;
  assign core_mode   = core_mode_r;
  assign blk_done    = blk_done_r;
  assign busy        = busy_r;
  assign mode_err    = mode_err_r;
  assign timeout_err = timeout_err_r;
  assign blk_count   = blk_count_r;

endmodule

// File: tb/tb_idct_block_scheduler.sv
// Directed self-checking bench for idct_block_scheduler.
module tb_idct_block_scheduler;

  logic        clk = 1'b0;
  logic        rst_b = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = 16'd0;
  logic        in_mode = 1'b0;
  logic        core_valid;
  logic [15:0] core_data;
  logic        core_mode;
  logic        core_out_start = 1'b0;
  logic        core_out_mode = 1'b0;
  logic        blk_done;
  logic        busy;
  logic        mode_err;
  logic        timeout_err;
  logic [7:0]  blk_count;

  int tests_run = 0;
  int tests_failed = 0;

  idct_block_scheduler dut (
    .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode), .core_valid(core_valid),
    .core_data(core_data), .core_mode(core_mode), .core_out_start(core_out_start),
    .core_out_mode(core_out_mode), .blk_done(blk_done), .busy(busy),
    .mode_err(mode_err), .timeout_err(timeout_err), .blk_count(blk_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_b = 1'b1; in_valid = 1'b0; core_out_start = 1'b0;
    step();
    rst_b = 1'b0;
    step();
  endtask

  task automatic send_block(input logic mode, input int base);
    for (int i = 0; i < 64; i++) begin
      in_valid = 1'b1; in_mode = mode; in_data = 16'(base + i);
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic drain_block(input logic mode);
    for (int n = 0; n < 64; n++) begin
      core_out_start = 1'b1; core_out_mode = mode;
      step();
    end
    core_out_start = 1'b0;
    step();
  endtask

  task automatic test_reset();
    logic [30:0] snap;
    rst_b = 1'b1;
    repeat (2) step();
    snap = {in_ready, core_valid, core_data, core_mode, blk_done, busy, mode_err, timeout_err, blk_count};
    tests_run++;
    if (snap !== 31'd0) begin
      tests_failed++; $display("FAIL reset_outputs: got %h expected %h", snap, 31'd0);
    end
    rst_b = 1'b0;
    step();
    tests_run++;
    if ({in_ready, busy} !== 2'b10) begin
      tests_failed++; $display("FAIL ready_after_reset: got %b expected %b", {in_ready, busy}, 2'b10);
    end
  endtask

  task automatic test_load_stream();
    logic [15:0] exp;
    for (int i = 0; i < 64; i++) begin
      in_valid = 1'b1; in_mode = 1'b0; exp = 16'(i - 32); in_data = exp;
      step();
      tests_run++;
      if ({core_valid, core_mode, core_data} !== {1'b1, 1'b0, exp}) begin
        tests_failed++;
        $display("FAIL load_forward[%0d]: got v=%b m=%b d=%h expected v=1 m=0 d=%h", i, core_valid, core_mode, core_data, exp);
      end
      tests_run++;
      if (in_ready !== (i < 63)) begin
        tests_failed++; $display("FAIL load_ready[%0d]: got %b expected %b", i, in_ready, (i < 63));
      end
    end
    in_data = 16'h0077;
    for (int k = 0; k < 3; k++) begin
      step();
      tests_run++;
      if ({core_valid, in_ready, busy, core_data} !== {1'b0, 1'b0, 1'b1, 16'h001F}) begin
        tests_failed++;
        $display("FAIL stall[%0d]: got v=%b r=%b busy=%b d=%h expected v=0 r=0 busy=1 d=001f", k, core_valid, in_ready, busy, core_data);
      end
    end
  endtask

  task automatic test_drain_gaps();
    int dones = 0;
    for (int n = 1; n <= 64; n++) begin
      if (n % 10 == 0 && n <= 50) begin
        core_out_start = 1'b0;
        step();
        tests_run++;
        if (blk_done !== 1'b0) begin
          tests_failed++; $display("FAIL gap_done[%0d]: got %b expected 0", n, blk_done);
        end
      end
      core_out_start = 1'b1; core_out_mode = 1'b0;
      step();
      if (blk_done === 1'b1) dones++;
      tests_run++;
      if (blk_done !== (n == 64)) begin
        tests_failed++; $display("FAIL drain_done[%0d]: got %b expected %b", n, blk_done, (n == 64));
      end
    end
    tests_run++;
    if (dones != 1) begin
      tests_failed++; $display("FAIL done_pulses: got %0d expected 1", dones);
    end
    tests_run++;
    if ({blk_count, busy, in_ready} !== {8'd1, 1'b0, 1'b0}) begin
      tests_failed++; $display("FAIL after_block: got cnt=%0d busy=%b r=%b expected cnt=1 busy=0 r=0", blk_count, busy, in_ready);
    end
    core_out_start = 1'b0;
    step();
    tests_run++;
    if ({core_valid, in_ready, blk_done} !== 3'b010) begin
      tests_failed++; $display("FAIL done_cycle_blocked: got %b expected 010", {core_valid, in_ready, blk_done});
    end
    step();
    tests_run++;
    if ({core_valid, core_data} !== {1'b1, 16'h0077}) begin
      tests_failed++; $display("FAIL held_data: got v=%b d=%h expected v=1 d=0077", core_valid, core_data);
    end
    for (int i = 1; i < 64; i++) begin
      in_data = 16'(i);
      step();
    end
    in_valid = 1'b0;
    drain_block(1'b0);
    tests_run++;
    if ({blk_count, mode_err, timeout_err} !== {8'd2, 1'b0, 1'b0}) begin
      tests_failed++; $display("FAIL second_block: got cnt=%0d me=%b te=%b expected cnt=2 me=0 te=0", blk_count, mode_err, timeout_err);
    end
  endtask

  task automatic test_mode_err();
    for (int i = 0; i < 64; i++) begin
      in_valid = 1'b1; in_mode = (i == 10); in_data = 16'(i);
      step();
      if (i == 9) begin
        tests_run++;
        if (mode_err !== 1'b0) begin
          tests_failed++; $display("FAIL mode_err_early: got %b expected 0", mode_err);
        end
      end
      if (i == 10) begin
        tests_run++;
        if ({mode_err, core_mode, core_data} !== {1'b1, 1'b0, 16'd10}) begin
          tests_failed++; $display("FAIL mode_err_set: got me=%b m=%b d=%h expected me=1 m=0 d=000a", mode_err, core_mode, core_data);
        end
      end
    end
    in_valid = 1'b0;
    drain_block(1'b0);
    tests_run++;
    if ({mode_err, blk_count} !== {1'b1, 8'd3}) begin
      tests_failed++; $display("FAIL mode_err_sticky: got me=%b cnt=%0d expected me=1 cnt=3", mode_err, blk_count);
    end
  endtask

  task automatic test_out_mode_err();
    apply_reset();
    core_out_start = 1'b1;
    step();
    core_out_start = 1'b0;
    tests_run++;
    if ({mode_err, busy, blk_done, blk_count} !== {1'b1, 1'b0, 1'b0, 8'd0}) begin
      tests_failed++; $display("FAIL idle_output: got me=%b busy=%b done=%b cnt=%0d expected me=1 busy=0 done=0 cnt=0", mode_err, busy, blk_done, blk_count);
    end
    apply_reset();
    send_block(1'b1, 100);
    tests_run++;
    if ({core_mode, core_data} !== {1'b1, 16'd163}) begin
      tests_failed++; $display("FAIL mode1_forward: got m=%b d=%0d expected m=1 d=163", core_mode, core_data);
    end
    for (int n = 1; n <= 64; n++) begin
      core_out_start = 1'b1; core_out_mode = (n != 5);
      step();
      if (n == 4 || n == 5) begin
        tests_run++;
        if (mode_err !== (n == 5)) begin
          tests_failed++; $display("FAIL out_mode[%0d]: got %b expected %b", n, mode_err, (n == 5));
        end
      end
    end
    core_out_start = 1'b0;
    step();
    tests_run++;
    if (blk_count !== 8'd1) begin
      tests_failed++; $display("FAIL out_mode_count: got %0d expected 1", blk_count);
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    send_block(1'b0, 0);
    repeat (254) step();
    tests_run++;
    if ({timeout_err, busy} !== 2'b01) begin
      tests_failed++; $display("FAIL timeout_early: got te=%b busy=%b expected te=0 busy=1", timeout_err, busy);
    end
    step();
    tests_run++;
    if ({timeout_err, busy, blk_done, blk_count} !== {1'b1, 1'b0, 1'b0, 8'd0}) begin
      tests_failed++; $display("FAIL timeout_hit: got te=%b busy=%b done=%b cnt=%0d expected te=1 busy=0 done=0 cnt=0", timeout_err, busy, blk_done, blk_count);
    end
  endtask

  task automatic test_reset_mid_block();
    logic [30:0] snap;
    apply_reset();
    for (int i = 0; i < 30; i++) begin
      in_valid = 1'b1; in_mode = 1'b1; in_data = 16'(i + 500);
      step();
    end
    in_data = 16'd530; rst_b = 1'b1;
    step();
    snap = {in_ready, core_valid, core_data, core_mode, blk_done, busy, mode_err, timeout_err, blk_count};
    tests_run++;
    if (snap !== 31'd0) begin
      tests_failed++; $display("FAIL mid_reset_outputs: got %h expected %h", snap, 31'd0);
    end
    rst_b = 1'b0; in_valid = 1'b0;
    step();
    for (int i = 0; i < 64; i++) begin
      in_valid = 1'b1; in_mode = 1'b0; in_data = 16'(i);
      step();
      if (i >= 62) begin
        tests_run++;
        if (in_ready !== (i == 62)) begin
          tests_failed++; $display("FAIL fresh_block_ready[%0d]: got %b expected %b", i, in_ready, (i == 62));
        end
      end
    end
    in_valid = 1'b0;
    drain_block(1'b0);
    tests_run++;
    if ({blk_count, mode_err} !== {8'd1, 1'b0}) begin
      tests_failed++; $display("FAIL fresh_block_done: got cnt=%0d me=%b expected cnt=1 me=0", blk_count, mode_err);
    end
  endtask

  task automatic test_count_wrap();
    apply_reset();
    for (int b = 0; b < 255; b++) begin
      send_block(1'b0, b);
      drain_block(1'b0);
    end
    tests_run++;
    if (blk_count !== 8'd255) begin
      tests_failed++; $display("FAIL count_255: got %0d expected 255", blk_count);
    end
    send_block(1'b0, 7);
    drain_block(1'b0);
    tests_run++;
    if ({blk_count, mode_err, timeout_err} !== {8'd0, 1'b0, 1'b0}) begin
      tests_failed++; $display("FAIL count_wrap: got cnt=%0d me=%b te=%b expected cnt=0 me=0 te=0", blk_count, mode_err, timeout_err);
    end
  endtask

  initial begin
    test_reset();
    test_load_stream();
    test_drain_gaps();
    test_mode_err();
    test_out_mode_err();
    test_timeout();
    test_reset_mid_block();
    test_count_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
